// File: rtl/assert_report_arbiter.sv
// Serializes violation pulses from N_CHK assertion checkers onto one report channel.
// Round-robin grant, per-checker timestamp capture, saturating drop count and sticky fail flag.
module assert_report_arbiter #(
    parameter int N_CHK = 4,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8,
    parameter int ID_W  = $clog2(N_CHK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CHK-1:0] enable_mask,
    input  logic [N_CHK-1:0] viol,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [ID_W-1:0]  report_id,
    output logic [TS_W-1:0]  report_ts,
    output logic             any_fail,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {IDLE, REPORT} state_t;

    localparam logic [CNT_W:0] DROP_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t            state, state_next;
    logic [TS_W-1:0]   ts;
    logic [N_CHK-1:0]  pending;
    logic [TS_W-1:0]   ts_cap [N_CHK];
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              do_grant;
    logic [N_CHK-1:0]  capture;
    logic [N_CHK-1:0]  granted;
    logic [N_CHK-1:0]  dropped;
    logic [CNT_W:0]    drop_sum;

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        idx         = 0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= N_CHK; k++) begin
            idx = (int'(rr) + k) % N_CHK;
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // In REPORT a grant is only allowed on the handshake edge.
    assign do_grant = grant_found && ((state == IDLE) || report_ready);

    always_comb begin
        capture  = '0;
        granted  = '0;
        dropped  = '0;
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < N_CHK; i++) begin
            capture[i] = viol[i] & enable_mask[i];
            granted[i] = do_grant && (grant_id == ID_W'(i));
            dropped[i] = capture[i] && pending[i] && !granted[i];
            drop_sum   = drop_sum + (CNT_W + 1)'(dropped[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = REPORT;
            REPORT:  if (report_ready && !grant_found) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        report_valid = (state == REPORT);
    end

    // A capture on a checker being granted this edge overwrites its slot instead of dropping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts        <= '0;
            pending   <= '0;
            rr        <= ID_W'(N_CHK - 1);
            report_id <= '0;
            report_ts <= '0;
            any_fail  <= 1'b0;
            drop_cnt  <= '0;
            for (int i = 0; i < N_CHK; i++) begin
                ts_cap[i] <= '0;
            end
        end else begin
            ts       <= ts + 1'b1;
            any_fail <= any_fail | (|capture);
            drop_cnt <= (drop_sum > DROP_MAX) ? DROP_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
            for (int i = 0; i < N_CHK; i++) begin
                if (capture[i] && !dropped[i]) begin
                    pending[i] <= 1'b1;
                    ts_cap[i]  <= ts;
                end else if (granted[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (do_grant) begin
                report_id <= grant_id;
                report_ts <= ts_cap[grant_id];
                rr        <= grant_id;
            end
        end
    end

endmodule
